mio_bus_ctrl: RTL and testbench

//  Memory/IO bus controller directly downstream of the MCPU memory port. Accepts one
//  CPU request at a time (CPU_MIO/mem_w/Addr_out/Data_out) and decodes it to word RAM,

---
 rtl/mio_bus_ctrl_pkg.sv | 19 +
 rtl/mio_bus_ctrl_if.sv | 18 +
 rtl/mio_addr_decode.sv | 29 ++
 rtl/mio_bus_ctrl.sv | 121 ++++++++++++
 tb/tb_mio_bus_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mio_bus_ctrl_pkg.sv
// Shared types for the MCPU memory/IO bus controller.
//   state_t  : controller FSM encoding
//   region_t : decoded target of a CPU request
//   WCNT_W   : width of the wait-state counter (waits 1..15)
//   wait_load: wait count to load for a decoded region
package mcpu_bus_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_WAIT, ST_RESP} state_t;
   typedef enum logic [1:0] {REG_RAM, REG_PER, REG_ERR} region_t;

   localparam logic [31:0] PERIPH_BASE_DEF = 32'hE000_0000;
   localparam int          WCNT_W          = 4;

   function automatic logic [WCNT_W-1:0] wait_load(input region_t r, input int ram_w,
                                                   input int per_w);
      return (r == REG_PER) ? WCNT_W'(per_w) : WCNT_W'(ram_w);
   endfunction

endpackage

// File: rtl/mio_bus_ctrl_if.sv
// CPU-side request/response bundle of the memory/IO bus controller.
//   cpu_mio/cpu_mem_w/cpu_addr/cpu_wdata : request from MCPU
//   cpu_rdata/mio_ready/bus_err          : response to MCPU
// master = CPU side, slave = controller side.
interface mio_bus_ctrl_if;
   logic        cpu_mio;
   logic        cpu_mem_w;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        mio_ready;
   logic        bus_err;

   modport master (output cpu_mio, cpu_mem_w, cpu_addr, cpu_wdata,
                   input  cpu_rdata, mio_ready, bus_err);
   modport slave  (input  cpu_mio, cpu_mem_w, cpu_addr, cpu_wdata,
                   output cpu_rdata, mio_ready, bus_err);
endinterface

// File: rtl/mio_addr_decode.sv
// Combinational address decoder.
//   addr   : CPU byte address
//   region : REG_ERR if misaligned, REG_RAM for the low RAM window,
//            REG_PER for the 256-byte peripheral window, else REG_ERR.
module mio_addr_decode
   import mcpu_bus_pkg::*;
#(
   parameter int          RAM_AW      = 10,
   parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF
) (
   input  logic [31:0] addr,
   output region_t     region
);

   // word index bits only matter downstream, not for the region
   logic unused_idx;
   assign unused_idx = ^addr[7:2];

   always_comb begin
      region = REG_ERR;
      if (addr[1:0] != 2'b00)
         region = REG_ERR;
      else if (addr[31:RAM_AW+2] == '0)
         region = REG_RAM;
      else if (addr[31:8] == PERIPH_BASE[31:8])
         region = REG_PER;
   end

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller behind the MCPU memory port.
//   clk, reset (async, active low)
//   bus      : CPU request/response (slave modport)
//   ram_*    : word RAM port, synchronous read data
//   per_*    : peripheral register port
// One request at a time: IDLE -> SETUP (strobe) -> WAIT (n cycles) -> RESP
// (one-cycle mio_ready). Rejected requests skip WAIT and flag bus_err.
module mio_bus_ctrl
   import mcpu_bus_pkg::*;
#(
   parameter int          RAM_AW      = 10,
   parameter int          RAM_WAIT    = 1,
   parameter int          PERIPH_WAIT = 2,
   parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF
) (
   input  logic              clk,
   input  logic              reset,
   mio_bus_ctrl_if.slave     bus,
   output logic              ram_en,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic              per_sel,
   output logic              per_we,
   output logic [5:0]        per_addr,
   output logic [31:0]       per_wdata,
   input  logic [31:0]       per_rdata
);

   state_t              state, nxt;
   region_t             region_d, region_q;
   logic                we_q;
   logic [RAM_AW-1:0]   ram_idx_q;
   logic [5:0]          per_idx_q;
   logic [31:0]         wdata_q;
   logic [31:0]         rdata_q;
   logic [WCNT_W-1:0]   wcnt;
   logic                last_wait;

   mio_addr_decode #(
      .RAM_AW      (RAM_AW),
      .PERIPH_BASE (PERIPH_BASE)
   ) u_dec (
      .addr   (bus.cpu_addr),
      .region (region_d)
   );

   assign last_wait = (wcnt == WCNT_W'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         region_q  <= REG_RAM;
         we_q      <= 1'b0;
         ram_idx_q <= '0;
         per_idx_q <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         wcnt      <= '0;
      end else begin
         state <= nxt;
         case (state)
            // request inputs are only looked at here
            ST_IDLE: if (bus.cpu_mio) begin
               we_q      <= bus.cpu_mem_w;
               ram_idx_q <= bus.cpu_addr[RAM_AW+1:2];
               per_idx_q <= bus.cpu_addr[7:2];
               wdata_q   <= bus.cpu_wdata;
               region_q  <= region_d;
            end
            ST_SETUP: begin
               wcnt <= wait_load(region_q, RAM_WAIT, PERIPH_WAIT);
               // rejected reads return zero in RESP
               if (region_q == REG_ERR && !we_q)
                  rdata_q <= '0;
            end
            ST_WAIT: begin
               wcnt <= wcnt - 1'b1;
               if (last_wait && !we_q)
                  rdata_q <= (region_q == REG_PER) ? per_rdata : ram_rdata;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      nxt           = state;
      ram_en        = 1'b0;
      ram_we        = 1'b0;
      per_sel       = 1'b0;
      per_we        = 1'b0;
      bus.mio_ready = 1'b0;
      bus.bus_err   = 1'b0;
      case (state)
         ST_IDLE:  if (bus.cpu_mio) nxt = ST_SETUP;
         ST_SETUP: begin
            ram_en  = (region_q == REG_RAM);
            ram_we  = (region_q == REG_RAM) && we_q;
            per_sel = (region_q == REG_PER);
            per_we  = (region_q == REG_PER) && we_q;
            nxt     = (region_q == REG_ERR) ? ST_RESP : ST_WAIT;
         end
         ST_WAIT:  if (last_wait) nxt = ST_RESP;
         ST_RESP: begin
            bus.mio_ready = 1'b1;
            bus.bus_err   = (region_q == REG_ERR);
            nxt           = ST_IDLE;
         end
         default:  nxt = ST_IDLE;
      endcase
   end

   assign ram_addr      = ram_idx_q;
   assign ram_wdata     = wdata_q;
   assign per_addr      = per_idx_q;
   assign per_wdata     = wdata_q;
   assign bus.cpu_rdata = rdata_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed bench for mio_bus_ctrl (RAM_WAIT=1, PERIPH_WAIT=2, RAM_AW=10).
// Inputs change and outputs are sampled on the falling edge.
module tb_mio_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        ram_en, ram_we, per_sel, per_we;
   logic [9:0]  ram_addr;
   logic [5:0]  per_addr;
   logic [31:0] ram_wdata, per_wdata;
   logic [31:0] ram_rdata = '0;
   logic [31:0] per_rdata = '0;
   logic [9:0]  ram_wr_addr = '0;
   logic [31:0] ram_wr_data = '0;
   logic [5:0]  per_wr_addr = '0;
   logic [31:0] per_wr_data = '0;
   int          tests = 0;
   int          fails = 0;

   mio_bus_ctrl_if bus ();

   mio_bus_ctrl #(
      .RAM_AW      (10),
      .RAM_WAIT    (1),
      .PERIPH_WAIT (2),
      .PERIPH_BASE (32'hE000_0000)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .per_sel   (per_sel),
      .per_we    (per_we),
      .per_addr  (per_addr),
      .per_wdata (per_wdata),
      .per_rdata (per_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ram_word(input logic [9:0] a);
      case (a)
         10'd0:   return 32'hCAFE_0000;
         10'd1:   return 32'h1234_5678;
         10'd4:   return 32'h014B_6024;
         default: return {22'h2A5A5, a};
      endcase
   endfunction

   // synchronous RAM and peripheral models
   always @(posedge clk) begin
      if (ram_en && !ram_we) ram_rdata <= ram_word(ram_addr);
      if (ram_en && ram_we) begin
         ram_wr_addr <= ram_addr;
         ram_wr_data <= ram_wdata;
      end
      if (per_sel && !per_we) per_rdata <= 32'h5000_0000 | {26'h0, per_addr};
      if (per_sel && per_we) begin
         per_wr_addr <= per_addr;
         per_wr_data <= per_wdata;
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // present a request in IDLE; returns at the falling edge after acceptance (SETUP)
   task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d);
      bus.cpu_mio   = 1'b1;
      bus.cpu_mem_w = we;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      cyc();
   endtask

   task automatic err_case(input string tag, input logic we, input logic [31:0] a,
                           input logic [31:0] exp_rdata);
      req(we, a, 32'hDEAD_BEEF);
      chk({tag, "_strobes"}, {30'h0, ram_en, per_sel}, 32'h0);
      chk({tag, "_early"}, {31'h0, bus.mio_ready}, 32'h0);
      bus.cpu_mio = 1'b0;
      cyc();
      chk({tag, "_resp"}, {30'h0, bus.mio_ready, bus.bus_err}, 32'h3);
      chk({tag, "_rdata"}, bus.cpu_rdata, exp_rdata);
      cyc();
      chk({tag, "_idle"}, {30'h0, bus.mio_ready, bus.bus_err}, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset         = 1'b0;
      bus.cpu_mio   = 1'b1;
      bus.cpu_mem_w = 1'b0;
      bus.cpu_addr  = 32'h0000_0010;
      bus.cpu_wdata = 32'h0;

      // reset held with a pending request
      cyc(); cyc();
      chk("rst_ctl", {26'h0, bus.mio_ready, bus.bus_err, ram_en, ram_we, per_sel, per_we}, 32'h0);
      chk("rst_rdata", bus.cpu_rdata, 32'h0);
      chk("rst_addr", {16'h0, ram_addr, per_addr}, 32'h0);
      chk("rst_wdata", ram_wdata | per_wdata, 32'h0);

      // release: read 0x10 accepted on the first edge
      reset = 1'b1;
      cyc();
      chk("rd10_en", {30'h0, ram_en, ram_we}, 32'h2);
      chk("rd10_addr", {22'h0, ram_addr}, 32'h4);
      chk("rd10_psel", {31'h0, per_sel}, 32'h0);
      cyc();
      chk("rd10_wait", {30'h0, ram_en, bus.mio_ready}, 32'h0);
      cyc();
      chk("rd10_resp", {30'h0, bus.mio_ready, bus.bus_err}, 32'h2);
      chk("rd10_rdata", bus.cpu_rdata, 32'h014B_6024);
      bus.cpu_mio = 1'b0;
      cyc();
      chk("rd10_idle", {31'h0, bus.mio_ready}, 32'h0);

      // peripheral write; cpu_mio dropped right after acceptance
      req(1'b1, 32'hE000_0008, 32'h0000_00FF);
      chk("pw_sel", {29'h0, per_sel, per_we, ram_en}, 32'h6);
      chk("pw_addr", {26'h0, per_addr}, 32'h2);
      chk("pw_wdata", per_wdata, 32'h0000_00FF);
      bus.cpu_mio = 1'b0;
      cyc();
      chk("pw_w1", {30'h0, per_sel, bus.mio_ready}, 32'h0);
      cyc();
      chk("pw_w2", {31'h0, bus.mio_ready}, 32'h0);
      cyc();
      chk("pw_resp", {30'h0, bus.mio_ready, bus.bus_err}, 32'h2);
      chk("pw_rdata", bus.cpu_rdata, 32'h014B_6024);
      chk("pw_landed", {per_wr_addr, 26'h0} | (per_wr_data & 32'hFF), 32'h0800_00FF);
      cyc();
      chk("pw_idle", {31'h0, bus.mio_ready}, 32'h0);

      // top RAM word write
      req(1'b1, 32'h0000_0FFC, 32'h89AB_CDEF);
      chk("rw_en", {30'h0, ram_en, ram_we}, 32'h3);
      chk("rw_addr", {22'h0, ram_addr}, 32'h3FF);
      bus.cpu_mio = 1'b0;
      cyc(); cyc();
      chk("rw_resp", {30'h0, bus.mio_ready, bus.bus_err}, 32'h2);
      chk("rw_landed", ram_wr_data, 32'h89AB_CDEF);
      chk("rw_landaddr", {22'h0, ram_wr_addr}, 32'h3FF);
      chk("rw_rdata", bus.cpu_rdata, 32'h014B_6024);
      cyc();

      // top peripheral word read
      req(1'b0, 32'hE000_00FC, 32'h0);
      chk("pr_sel", {30'h0, per_sel, per_we}, 32'h2);
      chk("pr_addr", {26'h0, per_addr}, 32'h3F);
      bus.cpu_mio = 1'b0;
      cyc(); cyc();
      chk("pr_w2", {31'h0, bus.mio_ready}, 32'h0);
      cyc();
      chk("pr_resp", {30'h0, bus.mio_ready, bus.bus_err}, 32'h2);
      chk("pr_rdata", bus.cpu_rdata, 32'h5000_003F);
      cyc();

      // rejected requests
      err_case("err_pw_oob", 1'b1, 32'hE000_0100, 32'h5000_003F);
      err_case("err_misal", 1'b0, 32'h0000_0006, 32'h0);
      err_case("err_unmap", 1'b0, 32'h8000_0000, 32'h0);
      err_case("err_ram_oob", 1'b0, 32'h0000_1000, 32'h0);

      // back-to-back reads with cpu_mio held high
      req(1'b0, 32'h0000_0000, 32'h0);
      chk("b2b0_addr", {21'h0, ram_en, ram_addr}, 32'h400);
      cyc();
      chk("b2b0_wait", {31'h0, bus.mio_ready}, 32'h0);
      cyc();
      chk("b2b0_resp", {31'h0, bus.mio_ready}, 32'h1);
      chk("b2b0_rdata", bus.cpu_rdata, 32'hCAFE_0000);
      bus.cpu_addr = 32'h0000_0004;
      cyc();
      chk("b2b_gap", {30'h0, bus.mio_ready, ram_en}, 32'h0);
      cyc();
      chk("b2b1_addr", {21'h0, ram_en, ram_addr}, 32'h401);
      cyc();
      chk("b2b1_wait", {31'h0, bus.mio_ready}, 32'h0);
      cyc();
      chk("b2b1_resp", {31'h0, bus.mio_ready}, 32'h1);
      chk("b2b1_rdata", bus.cpu_rdata, 32'h1234_5678);
      bus.cpu_mio = 1'b0;
      cyc();
      chk("b2b_idle", {31'h0, bus.mio_ready}, 32'h0);

      // reset during WAIT of a read
      req(1'b0, 32'h0000_0010, 32'h0);
      cyc();
      reset = 1'b0;
      #1;
      chk("rstw_ctl", {26'h0, bus.mio_ready, bus.bus_err, ram_en, ram_we, per_sel, per_we}, 32'h0);
      chk("rstw_rdata", bus.cpu_rdata, 32'h0);
      cyc(); cyc();
      chk("rstw_noready", {31'h0, bus.mio_ready}, 32'h0);
      reset = 1'b1;
      cyc();
      chk("rstw_accept", {22'h0, ram_en, 5'h0, ram_addr[3:0]}, 32'h204);
      cyc(); cyc();
      chk("rstw_resp", {30'h0, bus.mio_ready, bus.bus_err}, 32'h2);
      chk("rstw_rdata2", bus.cpu_rdata, 32'h014B_6024);
      bus.cpu_mio = 1'b0;
      cyc();
      chk("rstw_idle", {31'h0, bus.mio_ready}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
